// File: rtl/dmem_pkg.sv
// Shared types and widths for the M-stage data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read of the same index.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wd,
    output logic [WORD_W-1:0] rd
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents deliberately have no reset; software sees whatever was last stored.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wd;
        end
    end

    assign rd = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder with WAIT extra cycles per access and a stall to the hazard unit.
// Optional misaligned-access detection is enabled with DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WAIT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [WORD_W-1:0] aluoutM,
    input  logic [WORD_W-1:0] writedataM,
    output logic [WORD_W-1:0] readdataM,
    output logic              stallM,
    output logic              errM
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic              req;
    logic              reqMis;
    logic [AW-1:0]     reqIdx;
    logic              arrWe;
    logic [AW-1:0]     arrIdx;
    logic [WORD_W-1:0] arrWd;
    logic [WORD_W-1:0] arrRd;
    logic              unusedAddr;

    assign req        = memreadM | memwriteM;
    assign reqIdx     = aluoutM[AW+1:2];
    assign unusedAddr = ^{aluoutM[WORD_W-1:AW+2], aluoutM[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign reqMis = |aluoutM[1:0];
`else
    assign reqMis = 1'b0;
`endif

    dmem_array #(.DEPTH(DEPTH)) uArray (
        .clk (clk),
        .we  (arrWe),
        .idx (arrIdx),
        .wd  (arrWd),
        .rd  (arrRd)
    );

    generate
        if (WAIT == 0) begin : gZeroWait
            // Zero-wait memory: read is combinational, store lands on the closing edge.
            assign arrWe     = memwriteM & ~reqMis;
            assign arrIdx    = reqIdx;
            assign arrWd     = writedataM;
            assign readdataM = reqMis ? '0 : arrRd;
            assign stallM    = 1'b0;
            assign errM      = req & reqMis & ~reset;
        end else begin : gWaitFsm
            localparam int unsigned CW = (WAIT > 1) ? $clog2(WAIT) : 1;

            dmem_state_t       state, stateNext;
            logic [CW-1:0]     cnt, cntNext;
            logic [AW-1:0]     idxCap, idxNext;
            logic [WORD_W-1:0] wdCap, wdNext;
            logic              storeCap, storeNext;
            logic              misCap, misNext;
            logic [WORD_W-1:0] rdReg, rdNext;
            logic              errReg, errNext;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state    <= IDLE;
                    cnt      <= '0;
                    idxCap   <= '0;
                    wdCap    <= '0;
                    storeCap <= 1'b0;
                    misCap   <= 1'b0;
                    rdReg    <= '0;
                    errReg   <= 1'b0;
                end else begin
                    state    <= stateNext;
                    cnt      <= cntNext;
                    idxCap   <= idxNext;
                    wdCap    <= wdNext;
                    storeCap <= storeNext;
                    misCap   <= misNext;
                    rdReg    <= rdNext;
                    errReg   <= errNext;
                end
            end

            // Only captured request fields are used once the access leaves IDLE.
            always_comb begin
                stateNext = state;
                cntNext   = cnt;
                idxNext   = idxCap;
                wdNext    = wdCap;
                storeNext = storeCap;
                misNext   = misCap;
                rdNext    = rdReg;
                errNext   = 1'b0;
                arrWe     = 1'b0;
                case (state)
                    IDLE: begin
                        if (req) begin
                            idxNext   = reqIdx;
                            wdNext    = writedataM;
                            storeNext = memwriteM;
                            misNext   = reqMis;
                            cntNext   = CW'(WAIT - 1);
                            stateNext = BUSY;
                        end
                    end
                    BUSY: begin
                        if (cnt != '0) begin
                            cntNext = cnt - CW'(1);
                        end else begin
                            stateNext = DONE;
                            errNext   = misCap;
                            if (!storeCap) begin
                                rdNext = misCap ? '0 : arrRd;
                            end
                        end
                    end
                    DONE: begin
                        arrWe     = storeCap & ~misCap;
                        stateNext = IDLE;
                    end
                    default: stateNext = IDLE;
                endcase
            end

            assign arrIdx    = idxCap;
            assign arrWd     = wdCap;
            assign readdataM = rdReg;
            assign errM      = errReg;
            // Reset gating lets the stall drop the moment reset is asserted.
            assign stallM    = req & (state != DONE) & ~reset;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT=0/2/3) against a transaction-level memory model.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        int          d;
        bit          w;
        bit          r;
        logic [31:0] a;
        logic [31:0] data;
        logic [31:0] expRd;
        bit          chk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        mr    [3];
    logic        mw    [3];
    logic [31:0] addr  [3];
    logic [31:0] wd    [3];
    logic [31:0] rd    [3];
    logic        st    [3];
    logic        er    [3];

    logic [31:0] model  [3][64];
    bit          known  [3][64];
    logic [31:0] lastRd [3];

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .WAIT(0)) dut0 (
        .clk(clk), .reset(rst[0]), .memreadM(mr[0]), .memwriteM(mw[0]), .aluoutM(addr[0]),
        .writedataM(wd[0]), .readdataM(rd[0]), .stallM(st[0]), .errM(er[0]));
    dmem_responder #(.DEPTH(64), .WAIT(2)) dut1 (
        .clk(clk), .reset(rst[1]), .memreadM(mr[1]), .memwriteM(mw[1]), .aluoutM(addr[1]),
        .writedataM(wd[1]), .readdataM(rd[1]), .stallM(st[1]), .errM(er[1]));
    dmem_responder #(.DEPTH(64), .WAIT(3)) dut2 (
        .clk(clk), .reset(rst[2]), .memreadM(mr[2]), .memwriteM(mw[2]), .aluoutM(addr[2]),
        .writedataM(wd[2]), .readdataM(rd[2]), .stallM(st[2]), .errM(er[2]));

    function automatic int waitOf(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One access on instance d: drive, count stall cycles, check the completion cycle.
    task automatic access(input int d, input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] data, input bit useExp, input logic [31:0] expRd,
                          input bit chkRd);
        int          stalls;
        bit          done;
        bit          mis;
        bit          doRd;
        int          idx;
        int          wantStall;
        logic [31:0] want;
        mis = ALIGN && (a[1:0] != 2'b00);
        idx = int'(a[7:2]);
        if (w)        want = lastRd[d];
        else if (mis) want = 32'h0;
        else          want = model[d][idx];
        if (useExp) want = expRd;
        doRd = useExp ? chkRd : (w ? (waitOf(d) != 0) : (mis || known[d][idx]));
        wantStall = (waitOf(d) == 0) ? 0 : waitOf(d) + 1;

        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            mr[k] = 1'b0;
            mw[k] = 1'b0;
        end
        mw[d] = w; mr[d] = r; addr[d] = a; wd[d] = data;

        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (st[d]) begin
                stalls++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            nTests++;
            nFail++;
            $display("FAIL timeout: dut%0d stall never dropped, want %0d stall cycles", d, wantStall);
        end
        check($sformatf("stall_cycles d%0d a=%h", d, a), 32'(stalls), 32'(wantStall));
        if (doRd) check($sformatf("readdata d%0d a=%h", d, a), rd[d], want);
        check($sformatf("err d%0d a=%h", d, a), {31'b0, er[d]}, {31'b0, mis});

        if (w && !mis) begin
            model[d][idx] = data;
            known[d][idx] = 1'b1;
        end
        if (!w && waitOf(d) != 0) lastRd[d] = want;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [11];
        logic [31:0] a;
        int          op;

        vecs[0]  = '{1, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[1]  = '{1, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[2]  = '{0, 1'b1, 1'b0, 32'h0000_0004, 32'h1234_5678, 32'h0,         1'b0};
        vecs[3]  = '{0, 1'b0, 1'b1, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b1};
        vecs[4]  = '{1, 1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b1};
        vecs[5]  = '{1, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b1};
        vecs[6]  = '{1, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{2, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[8]  = '{2, 1'b0, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0001, 1'b1};
        vecs[9]  = '{0, 1'b1, 1'b1, 32'h0000_0044, 32'hFEED_C0DE, 32'h0,         1'b0};
        vecs[10] = '{0, 1'b0, 1'b1, 32'h0000_0044, 32'h0,         32'hFEED_C0DE, 1'b1};

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; mr[k] = 1'b0; mw[k] = 1'b0;
            addr[k] = '0; wd[k] = '0; lastRd[k] = '0;
        end

        // Reset for three cycles, then idle.
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        check("reset_rd1", rd[1], 32'h0);
        check("reset_rd2", rd[2], 32'h0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_stall%0d", k), {31'b0, st[k]}, 32'h0);
            check($sformatf("reset_err%0d", k), {31'b0, er[k]}, 32'h0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_stall1", {31'b0, st[1]}, 32'h0);
        end

        for (int i = 0; i < 11; i++) begin
            access(vecs[i].d, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].data, 1'b1,
                   vecs[i].expRd, vecs[i].chk);
        end

        // Reset in BUSY discards the pending store on the WAIT=3 instance.
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            mr[k] = 1'b0;
            mw[k] = 1'b0;
        end
        mw[2] = 1'b1; addr[2] = 32'h20; wd[2] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_busy_d2", {31'b0, st[2]}, 32'h1);
        rst[2] = 1'b1;
        #1;
        check("stall_on_reset_d2", {31'b0, st[2]}, 32'h0);
        check("rd_on_reset_d2", rd[2], 32'h0);
        @(posedge clk); #1;
        mw[2] = 1'b0;
        rst[2] = 1'b0;
        lastRd[2] = '0;
        access(2, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'h0000_0001, 1'b1);

        // Inputs changing during BUSY are ignored and a squashed store still commits.
        access(1, 1'b1, 1'b0, 32'h34, 32'h0000_0066, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        mr[1] = 1'b0; mw[1] = 1'b1; addr[1] = 32'h30; wd[1] = 32'h0000_0055;
        @(posedge clk); #1;
        addr[1] = 32'h34; wd[1] = 32'h0000_0099;
        @(posedge clk); #1;
        mw[1] = 1'b0;
        @(negedge clk);
        check("stall_squash_d1", {31'b0, st[1]}, 32'h0);
        repeat (2) @(posedge clk);
        model[1][12] = 32'h0000_0055; known[1][12] = 1'b1;
        access(1, 1'b0, 1'b1, 32'h30, 32'h0, 1'b1, 32'h0000_0055, 1'b1);
        access(1, 1'b0, 1'b1, 32'h34, 32'h0, 1'b1, 32'h0000_0066, 1'b1);

        @(posedge clk); #1;
        mr[1] = 1'b0; mw[1] = 1'b1; addr[1] = 32'h38; wd[1] = 32'h0000_0077;
        @(posedge clk); #1;
        mw[1] = 1'b0;
        repeat (3) @(posedge clk);
        model[1][14] = 32'h0000_0077; known[1][14] = 1'b1;
        access(1, 1'b0, 1'b1, 32'h38, 32'h0, 1'b1, 32'h0000_0077, 1'b1);

`ifdef DMEM_ALIGN_CHECK_EN
        access(1, 1'b1, 1'b0, 32'h20, 32'h1111_2222, 1'b0, 32'h0, 1'b0);
        access(1, 1'b1, 1'b0, 32'h22, 32'hBADB_AD00, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        mw[1] = 1'b0; mr[1] = 1'b0;
        @(negedge clk);
        check("err_pulse_ends_d1", {31'b0, er[1]}, 32'h0);
        access(1, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'h1111_2222, 1'b1);
        access(1, 1'b0, 1'b1, 32'h22, 32'h0, 1'b1, 32'h0000_0000, 1'b1);
        access(0, 1'b1, 1'b0, 32'h08, 32'h0BAD_0BAD, 1'b0, 32'h0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h09, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        access(0, 1'b0, 1'b1, 32'h08, 32'h0, 1'b1, 32'h0BAD_0BAD, 1'b1);
`endif

        // Random back-to-back traffic with aliasing and stray low address bits.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                op = int'($urandom_range(0, 2));
                a = $urandom();
                a[7:2] = 6'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                access(d, op != 1, op != 0, a, $urandom(), 1'b0, 32'h0, 1'b0);
            end
        end

        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            mr[k] = 1'b0;
            mw[k] = 1'b0;
        end
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's M-stage load/store port. It is the memory side of the aluoutM/writedataM/readdataM interface.
- Holds DEPTH 32-bit words.
- Models a configurable access latency and returns a stall to the hazard logic while an access is in flight.
- Sits between the datapath's M stage and the top-level memory map.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two.
- WAIT, 2, extra cycles per access. WAIT=0 gives a zero-wait memory.
- AW, $clog2(DEPTH), word-index width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- memreadM  in  1  load request (M stage).
- memwriteM  in  1  store request (M stage).
- aluoutM  in  32  byte address; word index = aluoutM[AW+1:2].
- writedataM  in  32  store data.
- readdataM  out  32  load data to the W-stage register.
- stallM  out  1  access in progress; core freezes F/D/E/M while high.
- errM  out  1  misaligned-access flag; present only with DMEM_ALIGN_CHECK_EN, otherwise tied 0.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, cnt=0, readdataM=0, stallM=0, errM=0.
  - Memory contents are not cleared.
- req = memreadM | memwriteM. If both are high, the access is a store (write wins); readdataM holds its previous value.
- WAIT=0:
  - No FSM; stallM is constant 0.
  - readdataM = mem[idx], combinational.
  - A store writes mem[idx] on the rising edge of clk when memwriteM=1.
- WAIT>0, FSM states IDLE, BUSY, DONE:
  - IDLE, req=1: capture idx, writedataM and the store flag; cnt<=WAIT-1; go to BUSY.
  - BUSY, cnt!=0: cnt<=cnt-1.
  - BUSY, cnt==0: go to DONE. For a load, readdataM<=mem[idx_captured].
  - DONE: for a store, mem[idx_captured]<=wdata_captured on the edge leaving DONE. Always go to IDLE.
  - stallM = req & (state!=DONE), combinational. It is high in the request cycle and all BUSY cycles.
  - Stall lasts exactly WAIT+1 cycles, and the access completes in cycle WAIT+2.
  - In DONE, readdataM is valid and stallM=0, so the core advances at the end of the DONE cycle.
- Request stability: the core holds M-stage inputs stable while stallM=1. The block uses captured values only; input changes during BUSY/DONE are ignored.
- req deasserted mid-access (squash): the FSM still runs to IDLE. A captured store is still committed.
- Back-to-back requests: a request present in the cycle after DONE starts a new access from IDLE. There is no pipelining of accesses.
- Address: only bits [AW+1:2] are used. Higher bits alias (wrap modulo DEPTH). Bits [1:0] are ignored unless the optional feature is enabled.
- Reset mid-access: return to IDLE, stallM drops immediately, and any pending store is discarded.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - aluoutM[1:0]!=0 with req=1 is misaligned.
  - The store is suppressed and a load returns 32'h0.
  - errM pulses high for one cycle: in DONE when WAIT>0, or in the request cycle when WAIT=0. Latency is unchanged.
- Undefined: no check, errM tied 0, and address bits [1:0] are ignored.

Decomposition:
- Package dmem_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t.
  - Localparam WORD_W=32.
- Sub-module dmem_array:
  - Single-port storage.
  - Synchronous write with we/idx/wd.
  - Combinational read of idx.
  - Parameterised by DEPTH.
- dmem_responder holds the FSM, counter, capture registers and stall/err logic.

Test Plan:
- Reset, WAIT=2: reset high 3 cycles then low → readdataM=0, stallM=0, errM=0; memwriteM=0/memreadM=0 idle → stallM stays 0.
- Store then load, WAIT=2: store 32'hDEADBEEF to addr 0x10 → stallM high exactly 3 cycles; load 0x10 → stallM high 3 cycles, then readdataM=32'hDEADBEEF in DONE with stallM=0.
- WAIT=0: store 32'h12345678 to 0x04, next cycle load 0x04 → stallM never 1; readdataM=32'h12345678 combinationally in the load cycle.
- Simultaneous/alias, DEPTH=64: memread=memwrite=1 to addr 0x100 with data 32'hA5A5A5A5 → treated as store; load 0x000 returns 32'hA5A5A5A5 (wraps modulo 256 bytes).
- Reset mid-store, WAIT=3: store 32'hCAFEF00D to 0x20 over old value 32'h1; assert reset in BUSY → stallM=0 at once; later load 0x20 returns 32'h1.
- DMEM_ALIGN_CHECK_EN: store to 0x22 → errM one-cycle pulse in DONE, memory unchanged; load 0x22 → readdataM=0, errM pulse.
